// File: rtl/oam_dma_engine.sv
// OAM DMA engine: on a write to 0xFF46 copies NUM_BYTES from page {src_hi, 8'h00} into OAM.
// dma_addr_select_o == 16'hFFFF tells the MMU no DMA is in progress, releasing CPU access to OAM.
module oam_dma_engine #(
    parameter int unsigned BYTE_PERIOD = 4,
    parameter int unsigned NUM_BYTES   = 160,
    parameter logic [15:0] OAM_BASE    = 16'hFE00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] mmio_addr_select_i,
    input  logic [7:0]  mmio_write_value_i,
    input  logic        mmio_write_enable_i,
    output logic [7:0]  mmio_read_out_o,
    output logic [15:0] dma_addr_select_o,
    output logic [7:0]  dma_write_value_o,
    output logic        dma_write_enable_o,
    input  logic [7:0]  dma_read_out_i,
    output logic        dma_busy_o
);
    localparam logic [15:0] RegAddr     = 16'hFF46;
    localparam logic [15:0] NoDma       = 16'hFFFF;
    localparam logic [7:0]  LastIdx     = 8'(NUM_BYTES - 1);
    localparam logic [15:0] WaitInit    = (BYTE_PERIOD > 3) ? 16'(BYTE_PERIOD - 4) : 16'd0;
    localparam bit          ShortPeriod = (BYTE_PERIOD == 3);

    typedef enum logic [2:0] {StIdle, StStart, StRead, StLatch, StWrite, StWait} state_e;

    state_e      state_q;
    logic [7:0]  src_hi_q;
    logic [7:0]  idx_q;
    logic [7:0]  data_q;
    logic [15:0] wait_q;
    logic [15:0] addr_q;
    logic        we_q;
    logic        busy_q;

    logic       reg_wr;
    logic       byte_done;
    logic       last_byte;
    logic [7:0] eff_hi;
    logic [7:0] idx_next;

    always_comb begin
        reg_wr    = mmio_write_enable_i && (mmio_addr_select_i == RegAddr);
        // Echo pages 0xE0-0xFF fold down onto WRAM so reads never hit OAM/IO.
        eff_hi    = (src_hi_q >= 8'hE0) ? (src_hi_q - 8'h20) : src_hi_q;
        byte_done = ((state_q == StWrite) && ShortPeriod) ||
                    ((state_q == StWait) && (wait_q == 16'd0));
        last_byte = (idx_q == LastIdx);
        idx_next  = idx_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            src_hi_q <= 8'hFF;
            idx_q    <= 8'd0;
            data_q   <= 8'd0;
            wait_q   <= 16'd0;
            addr_q   <= NoDma;
            we_q     <= 1'b0;
            busy_q   <= 1'b0;
        end else if (reg_wr) begin
            // Restart abandons the old copy; a WRITE in flight this cycle still lands at this edge.
            src_hi_q <= mmio_write_value_i;
            state_q  <= StStart;
            idx_q    <= 8'd0;
            addr_q   <= NoDma;
            we_q     <= 1'b0;
            busy_q   <= 1'b1;
        end else if (byte_done) begin
            we_q <= 1'b0;
            if (last_byte) begin
                state_q <= StIdle;
                addr_q  <= NoDma;
                busy_q  <= 1'b0;
            end else begin
                state_q <= StRead;
                idx_q   <= idx_next;
                addr_q  <= {eff_hi, idx_next};
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                end
                StStart: begin
                    state_q <= StRead;
                    idx_q   <= 8'd0;
                    addr_q  <= {eff_hi, 8'h00};
                end
                StRead: begin
                    state_q <= StLatch;
                end
                StLatch: begin
                    state_q <= StWrite;
                    data_q  <= dma_read_out_i;
                    addr_q  <= OAM_BASE + {8'h00, idx_q};
                    we_q    <= 1'b1;
                end
                StWrite: begin
                    state_q <= StWait;
                    wait_q  <= WaitInit;
                    we_q    <= 1'b0;
                end
                StWait: begin
                    wait_q <= wait_q - 16'd1;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign mmio_read_out_o    = src_hi_q;
    assign dma_addr_select_o  = addr_q;
    assign dma_write_value_o  = data_q;
    assign dma_write_enable_o = we_q;
    assign dma_busy_o         = busy_q;

endmodule
